id_ex_stage: RTL

//  ID/EX pipeline register of the 5-stage MIPS pipeline. Sits directly downstream of the ID-stage

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/hazard_detect_unit.sv | 31 +++
 rtl/id_ex_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the pipeline registers (ID/EX, EX/MEM,
//               MEM/WB): widths, ALUOp encodings and the bubble control word.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_NOP   = 2'b11;

  // Decoder control bits carried down the pipe with an instruction
  typedef struct packed {
    logic       reg_write;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       mem_read;
  } ctrl_t;

  // Control word of an empty slot: never writes architectural state
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'({1'b0, ALUOP_NOP, 1'b0, 1'b0});

endpackage
`default_nettype wire

// File: rtl/hazard_detect_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect_unit
// Description : Load-use hazard detector. Flags when the instruction in ID
//               reads the register a load sitting in EX has yet to deliver.
// Revision    : 1.0  initial release
// ============================================================================
module hazard_detect_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  output logic                  load_use_stall_o
);

  logic w_ex_is_load;
  logic w_src_match;

  // $0 is hard-wired zero, so a load targeting it can never create a hazard
  always_comb begin
    w_ex_is_load     = ex_valid_i & ex_mem_read_i & (ex_rt_i != '0);
    w_src_match      = (ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i);
    load_use_stall_o = id_valid_i & w_ex_is_load & w_src_match;
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register. Latches decoder control, operands and
//               register indices; inserts a bubble on load-use hazards, honours
//               flush and global hold, counts inserted load-use bubbles.
// Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W     = pipe_pkg::DATA_W,
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_RegWrite,
  input  logic [1:0]            id_ALUOp,
  input  logic                  id_MemWrite,
  input  logic                  id_MemRead,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [5:0]            id_funct,
  input  logic                  flush,
  input  logic                  hold,
  output logic                  ex_valid,
  output logic                  ex_RegWrite,
  output logic [1:0]            ex_ALUOp,
  output logic                  ex_MemWrite,
  output logic                  ex_MemRead,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [5:0]            ex_funct,
  output logic                  load_use_stall,
  output logic [CNT_W-1:0]      bubble_cnt
);

  import pipe_pkg::*;

  logic                  valid_q,   valid_d;
  ctrl_t                 ctrl_q,    ctrl_d;
  logic [DATA_W-1:0]     rs_data_q, rs_data_d;
  logic [DATA_W-1:0]     rt_data_q, rt_data_d;
  logic [REG_ADDR_W-1:0] rs_q,      rs_d;
  logic [REG_ADDR_W-1:0] rt_q,      rt_d;
  logic [REG_ADDR_W-1:0] rd_q,      rd_d;
  logic [5:0]            funct_q,   funct_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;

  logic                  w_stall;
  ctrl_t                 w_id_ctrl;

  hazard_detect_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .ex_valid_i       (valid_q),
    .ex_mem_read_i    (ctrl_q.mem_read),
    .ex_rt_i          (rt_q),
    .id_valid_i       (id_valid),
    .id_rs_i          (id_rs),
    .id_rt_i          (id_rt),
    .load_use_stall_o (w_stall)
  );

  // Next-state selection: flush > hold > load-use bubble > normal capture
  always_comb begin
    w_id_ctrl = ctrl_t'({id_RegWrite, id_ALUOp, id_MemWrite, id_MemRead});

    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    funct_d   = funct_q;
    cnt_d     = cnt_q;

    if (flush || (!hold && w_stall)) begin
      // Bubble: payload is zeroed so a dead slot never aliases a live index
      valid_d   = 1'b0;
      ctrl_d    = CTRL_BUBBLE;
      rs_data_d = '0;
      rt_data_d = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      funct_d   = '0;
      // Only a genuine load-use bubble is counted, and it saturates
      if (!flush && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!hold) begin
      valid_d   = id_valid;
      ctrl_d    = id_valid ? w_id_ctrl : CTRL_BUBBLE;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
      funct_d   = id_funct;
    end
  end

  // Pipeline register with synchronous reset to the bubble state
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= CTRL_BUBBLE;
      rs_data_q <= '0;
      rt_data_q <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      funct_q   <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      funct_q   <= funct_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_RegWrite    = ctrl_q.reg_write;
  assign ex_ALUOp       = ctrl_q.alu_op;
  assign ex_MemWrite    = ctrl_q.mem_write;
  assign ex_MemRead     = ctrl_q.mem_read;
  assign ex_rs_data     = rs_data_q;
  assign ex_rt_data     = rt_data_q;
  assign ex_rs          = rs_q;
  assign ex_rt          = rt_q;
  assign ex_rd          = rd_q;
  assign ex_funct       = funct_q;
  assign load_use_stall = w_stall;
  assign bubble_cnt     = cnt_q;

endmodule
`default_nettype wire
